// File: rtl/regfile_arb_pkg.sv
// Shared state encoding, default widths and the round-robin pick helper
// for the register-file port arbiter.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int MAX_REQ    = 4;

  // One-hot winner among the first n bits of valid, searching from ptr+1 upward.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [1:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] pick;
    logic [1:0]         idx;
    pick = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = 2'((int'(ptr) + i) % n);
      if (i <= n && pick == '0 && valid[idx]) pick[idx] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/regfile_rr_arbiter.sv
// Winner select plus last-winner pointer for the register-file arbiter.
// Define REGFILE_ARB_FIXED_PRIO_EN for strict lowest-index-wins priority.
module regfile_rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_idx
);

  logic [MAX_REQ-1:0] valid_w;
  logic [MAX_REQ-1:0] pick_w;

  assign valid_w = MAX_REQ'(req_valid);

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_w = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (valid_w[i]) begin
        pick_w    = '0;
        pick_w[i] = 1'b1;
      end
    end
  end
`else
  logic [1:0] ptr;

  assign pick_w = rr_pick(valid_w, ptr, NUM_REQ);

  // Pointer starts at the top index so requester 0 wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) ptr <= 2'(NUM_REQ - 1);
    else if (advance && |req_valid) ptr <= grant_idx;
  end
`endif

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick_w[i]) grant_idx = 2'(i);
    end
  end

  assign grant = pick_w[NUM_REQ-1:0];

endmodule

// File: rtl/regfile_port_arbiter.sv
// Serialises write and dual-read ops from NUM_REQ requesters onto the 16x32
// register file pins. Arbitration mode set by REGFILE_ARB_FIXED_PRIO_EN.
//
// state | meaning
// IDLE  | wait for a request, grant one and latch its op
// ISSUE | drive EN with WR or RD for one cycle
// WAIT  | hold EN/RD for RD_LATENCY cycles, capture on the last
// RESP  | pulse rsp_valid to the owner
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_waddr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*ADDR_W-1:0] req_raddr_a,
  input  logic [NUM_REQ*ADDR_W-1:0] req_raddr_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata_a,
  output logic [DATA_W-1:0]         rsp_rdata_b,
  output logic                      rf_en,
  output logic                      rf_wr,
  output logic                      rf_rd,
  output logic [ADDR_W-1:0]         rf_sel_i1,
  output logic [DATA_W-1:0]         rf_ip1,
  output logic [ADDR_W-1:0]         rf_sel_o1,
  output logic [ADDR_W-1:0]         rf_sel_o2,
  input  logic [DATA_W-1:0]         rf_op1,
  input  logic [DATA_W-1:0]         rf_op2,
  output logic                      busy
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("regfile_port_arbiter: NUM_REQ must be in 2..4");
  end
  if (RD_LATENCY < 0 || RD_LATENCY > 3) begin : g_bad_rd_latency
    $error("regfile_port_arbiter: RD_LATENCY must be in 0..3");
  end

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_ISSUE   = ST_ISSUE;
  localparam logic [1:0] S_WAIT    = ST_WAIT;
  localparam logic [1:0] S_RESP    = ST_RESP;
  localparam logic [1:0] WAIT_LOAD = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

  logic [1:0]         state;
  logic [1:0]         owner;
  logic               op_we;
  logic [1:0]         wait_cnt;
  logic               accept;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_idx;

  // Zero-extend the flat request buses to MAX_REQ so a 2-bit index is always in range.
  logic [MAX_REQ-1:0]        we_x;
  logic [MAX_REQ*ADDR_W-1:0] waddr_x, raddr_a_x, raddr_b_x;
  logic [MAX_REQ*DATA_W-1:0] wdata_x;
  logic [MAX_REQ-1:0]        we_arr;
  logic [ADDR_W-1:0]         waddr_arr   [MAX_REQ];
  logic [ADDR_W-1:0]         raddr_a_arr [MAX_REQ];
  logic [ADDR_W-1:0]         raddr_b_arr [MAX_REQ];
  logic [DATA_W-1:0]         wdata_arr   [MAX_REQ];

  assign we_x      = MAX_REQ'(req_we);
  assign waddr_x   = (MAX_REQ*ADDR_W)'(req_waddr);
  assign raddr_a_x = (MAX_REQ*ADDR_W)'(req_raddr_a);
  assign raddr_b_x = (MAX_REQ*ADDR_W)'(req_raddr_b);
  assign wdata_x   = (MAX_REQ*DATA_W)'(req_wdata);

  always_comb begin
    we_arr = we_x;
    for (int i = 0; i < MAX_REQ; i++) begin
      waddr_arr[i]   = waddr_x[i*ADDR_W +: ADDR_W];
      raddr_a_arr[i] = raddr_a_x[i*ADDR_W +: ADDR_W];
      raddr_b_arr[i] = raddr_b_x[i*ADDR_W +: ADDR_W];
      wdata_arr[i]   = wdata_x[i*DATA_W +: DATA_W];
    end
  end

  // A grant is only honoured in IDLE and never in a reset cycle.
  assign accept = (state == S_IDLE) && !rst;

  regfile_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = accept ? grant : '0;
  assign rsp_valid = (state == S_RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign busy      = (state != S_IDLE);
  assign rf_en     = (state == S_ISSUE) || (state == S_WAIT);
  assign rf_wr     = (state == S_ISSUE) && op_we;
  assign rf_rd     = ((state == S_ISSUE) && !op_we) || (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= '0;
      op_we       <= 1'b0;
      wait_cnt    <= '0;
      rf_sel_i1   <= '0;
      rf_ip1      <= '0;
      rf_sel_o1   <= '0;
      rf_sel_o2   <= '0;
      rsp_rdata_a <= '0;
      rsp_rdata_b <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            owner <= grant_idx;
            op_we <= we_arr[grant_idx];
            if (we_arr[grant_idx]) begin
              rf_sel_i1 <= waddr_arr[grant_idx];
              rf_ip1    <= wdata_arr[grant_idx];
            end else begin
              rf_sel_o1 <= raddr_a_arr[grant_idx];
              rf_sel_o2 <= raddr_b_arr[grant_idx];
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_we) begin
            rsp_rdata_a <= '0;
            rsp_rdata_b <= '0;
            state       <= S_RESP;
          end else if (RD_LATENCY == 0) begin
            rsp_rdata_a <= rf_op1;
            rsp_rdata_b <= rf_op2;
            state       <= S_RESP;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            rsp_rdata_a <= rf_op1;
            rsp_rdata_b <= rf_op2;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench: three arbiters (RD_LATENCY 1, 0, 3), each with its own
// register-file model that only presents data in the cycle it becomes valid.
module tb_regfile_port_arbiter;

  localparam logic [31:0] GARB = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rv [3];
  logic [1:0]  req_we;
  logic [7:0]  req_waddr, req_raddr_a, req_raddr_b;
  logic [63:0] req_wdata;

  logic [1:0]  req_ready [3];
  logic [1:0]  rsp_valid [3];
  logic [31:0] rsp_rdata_a [3], rsp_rdata_b [3];
  logic [31:0] rf_ip1 [3], rf_op1 [3], rf_op2 [3];
  logic        rf_en [3], rf_wr [3], rf_rd [3], busy [3];
  logic [3:0]  rf_sel_i1 [3], rf_sel_o1 [3], rf_sel_o2 [3];

  int          total  = 0;
  int          passed = 0;
  logic [3:0]  last_wsel;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_d
    localparam int L  = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    localparam int DI = (L == 0) ? 0 : L - 1;
    logic [31:0] mem [16];
    logic [3:0]  rd_dly;
    logic [3:0]  s1_d [4];
    logic [3:0]  s2_d [4];

    regfile_port_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(4), .RD_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .req_valid(rv[g]), .req_we(req_we),
      .req_waddr(req_waddr), .req_wdata(req_wdata),
      .req_raddr_a(req_raddr_a), .req_raddr_b(req_raddr_b),
      .req_ready(req_ready[g]), .rsp_valid(rsp_valid[g]),
      .rsp_rdata_a(rsp_rdata_a[g]), .rsp_rdata_b(rsp_rdata_b[g]),
      .rf_en(rf_en[g]), .rf_wr(rf_wr[g]), .rf_rd(rf_rd[g]),
      .rf_sel_i1(rf_sel_i1[g]), .rf_ip1(rf_ip1[g]),
      .rf_sel_o1(rf_sel_o1[g]), .rf_sel_o2(rf_sel_o2[g]),
      .rf_op1(rf_op1[g]), .rf_op2(rf_op2[g]), .busy(busy[g]));

    always @(posedge clk) begin
      if (rf_en[g] && rf_wr[g]) mem[rf_sel_i1[g]] <= rf_ip1[g];
      rd_dly  <= rst ? 4'd0 : {rd_dly[2:0], rf_en[g] & rf_rd[g]};
      s1_d[0] <= rf_sel_o1[g];
      s2_d[0] <= rf_sel_o2[g];
      for (int k = 1; k < 4; k++) begin
        s1_d[k] <= s1_d[k-1];
        s2_d[k] <= s2_d[k-1];
      end
    end

    // Data is valid exactly L cycles after RD is first driven; garbage otherwise.
    assign rf_op1[g] = (L == 0) ? ((rf_en[g] && rf_rd[g]) ? mem[rf_sel_o1[g]] : GARB)
                                : (rd_dly[DI] ? mem[s1_d[DI]] : GARB);
    assign rf_op2[g] = (L == 0) ? ((rf_en[g] && rf_rd[g]) ? mem[rf_sel_o2[g]] : GARB)
                                : (rd_dly[DI] ? mem[s2_d[DI]] : GARB);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_req(input int r, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] ra, input logic [3:0] rb);
    req_we[r]             = we;
    req_waddr[r*4 +: 4]   = wa;
    req_wdata[r*32 +: 32] = wd;
    req_raddr_a[r*4 +: 4] = ra;
    req_raddr_b[r*4 +: 4] = rb;
  endtask

  // lat = clock edges from the req_ready cycle to the rsp_valid cycle.
  task automatic run_op(input int d, input int r, output int lat, output int rd_cyc,
                        output int wr_cyc, output logic [31:0] da, output logic [31:0] db);
    int n = 0;
    rv[d][r] = 1'b1;
    #1;
    while (!req_ready[d][r] && n < 20) begin
      tick();
      n++;
    end
    chk("grant_seen", 32'(req_ready[d][r]), 32'd1);
    tick();
    rv[d][r] = 1'b0;
    #1;
    lat = 1; rd_cyc = 0; wr_cyc = 0;
    while (!rsp_valid[d][r] && lat < 20) begin
      if (rf_en[d] && rf_rd[d]) rd_cyc++;
      if (rf_en[d] && rf_wr[d]) begin
        wr_cyc++;
        last_wsel  = rf_sel_i1[d];
        last_wdata = rf_ip1[d];
      end
      tick();
      lat++;
    end
    da = rsp_rdata_a[d];
    db = rsp_rdata_b[d];
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, rdc, wrc, n, ng, seen1;
    int          gseq [4];
    logic [31:0] da, db;

    rst = 1'b1;
    rv  = '{default: '0};
    req_we = '0; req_waddr = '0; req_wdata = '0; req_raddr_a = '0; req_raddr_b = '0;
    repeat (3) tick();

    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_rf_en", 32'(rf_en[0]), 0);
    chk("rst_rf_rd", 32'(rf_rd[0]), 0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 0);
    chk("rst_rdata_a", rsp_rdata_a[0], 0);
    chk("rst_ip1", rf_ip1[0], 0);
    rst = 1'b0;
    tick();

    // Write, write, read back on the RD_LATENCY=1 instance.
    set_req(0, 1'b1, 4'h0, 32'hABCD_EFAB, 4'h0, 4'h0);
    run_op(0, 0, lat, rdc, wrc, da, db);
    chk("wr0_lat", 32'(lat), 2);
    chk("wr0_wr_cycles", 32'(wrc), 1);
    set_req(0, 1'b1, 4'h1, 32'h0123_4567, 4'h0, 4'h0);
    run_op(0, 0, lat, rdc, wrc, da, db);
    set_req(0, 1'b0, 4'h0, 32'h0, 4'h0, 4'h1);
    run_op(0, 0, lat, rdc, wrc, da, db);
    chk("rd01_data_a", da, 32'hABCD_EFAB);
    chk("rd01_data_b", db, 32'h0123_4567);
    chk("rd01_lat", 32'(lat), 3);       // rsp in the 4th cycle counting the grant cycle
    chk("rd01_rd_cycles", 32'(rdc), 2);

    // Write cycle pins, requester 1.
    set_req(1, 1'b1, 4'hF, 32'hDEAD_BEEF, 4'h0, 4'h0);
    run_op(0, 1, lat, rdc, wrc, da, db);
    chk("wr15_wr_cycles", 32'(wrc), 1);
    chk("wr15_sel_i1", 32'(last_wsel), 32'hF);
    chk("wr15_ip1", last_wdata, 32'hDEAD_BEEF);
    chk("wr15_rdata_a", da, 0);
    chk("wr15_rdata_b", db, 0);
    chk("wr15_rd_cycles", 32'(rdc), 0);

    set_req(0, 1'b1, 4'h2, 32'h2222_2222, 4'h0, 4'h0);
    run_op(0, 0, lat, rdc, wrc, da, db);
    set_req(1, 1'b1, 4'h3, 32'h3333_3333, 4'h0, 4'h0);
    run_op(0, 1, lat, rdc, wrc, da, db);

    // Contention: both requesters hold reads; record grant order.
    set_req(0, 1'b0, 4'h0, 32'h0, 4'h2, 4'h3);
    set_req(1, 1'b0, 4'h0, 32'h0, 4'h3, 4'h2);
    rv[0] = 2'b11;
    #1;
    ng = 0; n = 0;
    while (ng < 4 && n < 60) begin
      if (req_ready[0] != 2'b00) begin
        gseq[ng] = (req_ready[0] == 2'b01) ? 0 : (req_ready[0] == 2'b10) ? 1 : 9;
        ng++;
      end
      tick();
      n++;
    end
    rv[0] = 2'b00;
    chk("cont_grants", 32'(ng), 4);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    chk("cont_g0", 32'(gseq[0]), 0);
    chk("cont_g1", 32'(gseq[1]), 0);
    chk("cont_g2", 32'(gseq[2]), 0);
    chk("cont_g3", 32'(gseq[3]), 0);
`else
    chk("cont_g0", 32'(gseq[0]), 0);
    chk("cont_g1", 32'(gseq[1]), 1);
    chk("cont_g2", 32'(gseq[2]), 0);
    chk("cont_g3", 32'(gseq[3]), 1);
`endif
    n = 0;
    while (busy[0] && n < 20) begin
      tick();
      n++;
    end
    chk("cont_drained", 32'(busy[0]), 0);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    chk("cont_last_data", rsp_rdata_a[0], 32'h2222_2222);
`else
    chk("cont_last_data", rsp_rdata_a[0], 32'h3333_3333);
`endif

    // Withdrawn request: req1 raised for one cycle while req0's write is in flight.
    set_req(0, 1'b1, 4'h6, 32'h6666_6666, 4'h0, 4'h0);
    set_req(1, 1'b0, 4'h0, 32'h0, 4'h1, 4'h1);
    rv[0] = 2'b01;
    #1;
    chk("wd_grant0", 32'(req_ready[0]), 32'h1);
    tick();
    rv[0] = 2'b10;
    #1;
    seen1 = int'(req_ready[0][1]);
    tick();
    rv[0] = 2'b00;
    #1;
    chk("wd_rsp0", 32'(rsp_valid[0]), 32'h1);
    seen1 += int'(req_ready[0][1]);
    tick();
    chk("wd_busy_low", 32'(busy[0]), 0);
    for (int i = 0; i < 4; i++) begin
      seen1 += int'(req_ready[0][1]) + int'(rsp_valid[0][1]) + int'(busy[0]);
      tick();
    end
    chk("wd_no_req1_activity", 32'(seen1), 0);

    // Latency sweep on the RD_LATENCY=0 and RD_LATENCY=3 instances.
    for (int d = 1; d <= 2; d++) begin
      int le;
      le = (d == 1) ? 0 : 3;
      set_req(0, 1'b1, 4'h5, 32'h5A5A_5A5A, 4'h0, 4'h0);
      run_op(d, 0, lat, rdc, wrc, da, db);
      set_req(0, 1'b1, 4'h7, 32'h7777_0000 + 32'(d), 4'h0, 4'h0);
      run_op(d, 0, lat, rdc, wrc, da, db);
      set_req(0, 1'b0, 4'h0, 32'h0, 4'h5, 4'h7);
      run_op(d, 0, lat, rdc, wrc, da, db);
      chk($sformatf("sweep%0d_data_a", le), da, 32'h5A5A_5A5A);
      chk($sformatf("sweep%0d_data_b", le), db, 32'h7777_0000 + 32'(d));
      chk($sformatf("sweep%0d_lat", le), 32'(lat), 32'(2 + le));
      chk($sformatf("sweep%0d_rd_cycles", le), 32'(rdc), 32'(1 + le));
    end

    // Reset during WAIT aborts the read; pointer returns to favour req0.
    set_req(0, 1'b0, 4'h0, 32'h0, 4'h3, 4'h2);
    rv[0] = 2'b01;
    #1;
    chk("abort_grant0", 32'(req_ready[0]), 32'h1);
    tick();
    rv[0] = 2'b00;
    tick();
    chk("abort_in_wait_rd", 32'(rf_rd[0]), 1);
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_rf_en", 32'(rf_en[0]), 0);
    chk("abort_rf_rd", 32'(rf_rd[0]), 0);
    chk("abort_sel_o1", 32'(rf_sel_o1[0]), 0);
    chk("abort_sel_o2", 32'(rf_sel_o2[0]), 0);
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n += int'(rsp_valid[0] != 2'b00) + int'(busy[0]);
    end
    chk("abort_no_rsp", 32'(n), 0);
    rv[0] = 2'b11;
    #1;
    chk("abort_next_grant", 32'(req_ready[0]), 32'h1);
    tick();
    rv[0] = 2'b00;
    n = 0;
    while (busy[0] && n < 20) begin
      tick();
      n++;
    end
    chk("abort_final_idle", 32'(busy[0]), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
